// File: rtl/gpu_draw_pkg.sv
// Shared types and constants for the line-draw engine arbiter.
package gpu_draw_pkg;

  localparam int NUM_REQ = 3;
  localparam int COORD_W = 8;
  localparam int TMO_W   = 12;
  localparam logic [TMO_W-1:0] TIMEOUT_MAX = 12'd4095;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Round-robin pointer moves to the requester just after the one served.
  function automatic logic [1:0] next_ptr(input logic [NUM_REQ-1:0] g);
    logic [1:0] p;
    p = 2'd0;
    if (g[0]) p = 2'd1;
    else if (g[1]) p = 2'd2;
    return p;
  endfunction

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import gpu_draw_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    gnt   = '0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = 2'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one line-draw engine among three requesters.
// Optional watchdog abort when DRAW_ARB_TIMEOUT_EN is defined.
module draw_arbiter
  import gpu_draw_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] coord_in,
  input  logic                 draw_done,
  output logic [COORD_W-1:0]   x0,
  output logic [COORD_W-1:0]   y0,
  output logic [COORD_W-1:0]   x1,
  output logic [COORD_W-1:0]   y1,
  output logic                 draw_en,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 timeout_err
);

  state_t             state;
  logic [1:0]         ptr;
  logic [31:0]        seg;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_valid;
  logic [31:0]        pick_seg;
  logic               tmo_hit;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_seg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_seg = pick_seg | coord_in[32*i +: 32];
    end
  end

`ifdef DRAW_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == DRAW) && (tmo_cnt == TIMEOUT_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == DRAW) tmo_cnt <= tmo_cnt + 1'b1;
      else               tmo_cnt <= '0;
      // A draw_done arriving on the last allowed cycle is a normal completion.
      timeout_err <= tmo_hit && !draw_done;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      seg   <= '0;
      grant <= '0;
      done  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            seg   <= pick_seg;
            grant <= pick_gnt;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (draw_done || tmo_hit) begin
            seg   <= '0;
            done  <= grant;
            ptr   <= next_ptr(grant);
            state <= GAP;
          end
        end
        GAP: begin
          grant <= '0;
          done  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The latch is only non-zero while in DRAW, so endpoints need no extra gating.
  assign x0      = seg[COORD_W-1:0];
  assign y0      = seg[2*COORD_W-1:COORD_W];
  assign x1      = seg[3*COORD_W-1:2*COORD_W];
  assign y1      = seg[4*COORD_W-1:3*COORD_W];
  assign draw_en = (state == DRAW);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected grant/segment pushed at stimulus, popped on each done pulse.
module tb_draw_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  req;
  logic [95:0] coord_in;
  logic        draw_done;
  logic [7:0]  x0, y0, x1, y1;
  logic        draw_en;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        timeout_err;

  draw_arbiter dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req         (req),
    .coord_in    (coord_in),
    .draw_done   (draw_done),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .draw_en     (draw_en),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  grant;
    logic [31:0] seg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] obs_seg = '0;
  bit          tmo_seen = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    if (draw_en) obs_seg = {y1, x1, y0, x0};
    if (timeout_err) tmo_seen = 1'b1;
    if (done != 3'b000) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_onehot", 32'(done), 32'(mon_e.grant));
        check("done_grant", 32'(grant), 32'(mon_e.grant));
        check("done_seg", obs_seg, mon_e.seg);
        check("gap_draw_en", 32'(draw_en), 32'd0);
        check("gap_coords", {y1, x1, y0, x0}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_draw_en"}, 32'(draw_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    check({tag, "_coords"}, {y1, x1, y0, x0}, 32'd0);
  endtask

  task automatic wait_draw(input string tag);
    int n;
    n = 0;
    while (!draw_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_started"}, 32'(draw_en), 32'd1);
  endtask

  // Called in the first DRAW cycle; keeps DRAW for 'cycles' cycles then returns in GAP.
  task automatic finish_line(input string tag, input int cycles);
    int hi;
    hi = 0;
    for (int k = 0; k < cycles; k++) begin
      if (draw_en) hi++;
      if (k < cycles - 1) tick();
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    check({tag, "_draw_len"}, 32'(hi), 32'(cycles));
    check({tag, "_gap_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    sb.delete();
  endtask

  localparam logic [31:0] SEG0 = 32'h44332211;
  localparam logic [31:0] SEG1 = 32'h88776655;
  localparam logic [31:0] SEG2 = 32'hCCBBAA99;

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [31:0] rr_seg [4] = '{SEG0, SEG1, SEG2, SEG0};

  initial begin
    n_rst     = 1'b0;
    req       = '0;
    coord_in  = '0;
    draw_done = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    n_rst = 1'b1;
    tick();

    // Single requester, known segment, five DRAW cycles.
    coord_in[31:0] = 32'h1E140A05;
    req = 3'b001;
    sb.push_back('{3'b001, 32'h1E140A05});
    tick();
    check("lat_draw_en", 32'(draw_en), 32'd1);
    check("s1_grant", 32'(grant), 32'b001);
    check("s1_x0", 32'(x0), 32'h05);
    check("s1_y0", 32'(y0), 32'h0A);
    check("s1_x1", 32'(x1), 32'h14);
    check("s1_y1", 32'(y1), 32'h1E);
    req = 3'b000;
    finish_line("s1", 5);
    tick();
    check_quiet("s1_idle");

    // All three requesting continuously from a fresh reset.
    do_reset();
    coord_in = {SEG2, SEG1, SEG0};
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rr_exp[i], rr_seg[i]});
      wait_draw("rr");
      check("rr_grant", 32'(grant), 32'(rr_exp[i]));
      finish_line("rr", 2 + i);
    end
    req = 3'b000;

    // Requester drops its request and changes coordinates mid-DRAW.
    tick();
    coord_in[63:32] = 32'h5A4B3C2D;
    req = 3'b010;
    sb.push_back('{3'b010, 32'h5A4B3C2D});
    wait_draw("s3");
    check("s3_grant", 32'(grant), 32'b010);
    req = 3'b000;
    coord_in = {96{1'b1}};
    tick();
    check("s3_hold_seg", {y1, x1, y0, x0}, 32'h5A4B3C2D);
    tick();
    check("s3_hold_grant", 32'(grant), 32'b010);
    check("s3_hold_en", 32'(draw_en), 32'd1);
    // draw_done stays high through GAP and IDLE; only the DRAW sample may count.
    draw_done = 1'b1;
    tick();
    tick();
    tick();
    check_quiet("s3_idle_done");
    tick();
    check_quiet("s3_idle_done2");
    draw_done = 1'b0;

    // Reset in the middle of DRAW with ptr at 2.
    do_reset();
    coord_in = {SEG2, SEG1, SEG0};
    req = 3'b111;
    sb.push_back('{3'b001, SEG0});
    wait_draw("s5a");
    finish_line("s5a", 2);
    sb.push_back('{3'b010, SEG1});
    wait_draw("s5b");
    finish_line("s5b", 2);
    wait_draw("s5c");
    check("s5_grant_ptr2", 32'(grant), 32'b100);
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check_quiet("async_rst");
    tick();
    n_rst = 1'b1;
    sb.push_back('{3'b001, SEG0});
    wait_draw("s5d");
    check("s5_first_grant", 32'(grant), 32'b001);
    req = 3'b000;
    finish_line("s5d", 3);
    tick();

    // No draw_done: watchdog abort, or indefinite DRAW without the option.
    coord_in[31:0] = 32'h0F0E0D0C;
    req = 3'b001;
    sb.push_back('{3'b001, 32'h0F0E0D0C});
    wait_draw("s6");
    req = 3'b000;
    tmo_seen = 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!timeout_err && n < 5000) begin
        tick();
        n++;
      end
      check("tmo_fired", 32'(timeout_err), 32'd1);
      check("tmo_window", 32'(n >= 4095 && n <= 4096), 32'd1);
      tick();
      check_quiet("tmo_idle");
    end
`else
    repeat (4200) tick();
    check("notmo_draw_en", 32'(draw_en), 32'd1);
    check("notmo_grant", 32'(grant), 32'b001);
    check("notmo_no_err", 32'(tmo_seen), 32'd0);
    finish_line("s6", 1);
    tick();
    check_quiet("s6_idle");
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
